addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_if.sv | 44 ++++
 rtl/addsub_arbiter.sv | 157 +++++++++++++++
 tb/tb_addsub_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for addsub_arbiter.
//   master : two requesters (valid, x, y, sub) plus the response consumer (rsp_ready)
//   slave  : the arbiter (req ready outputs and the registered response slot)
// Parameter N is the operand/result width and must match the arbiter's N.
interface addsub_arbiter_if #(
  parameter int unsigned N = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_x;
  logic [N-1:0] req0_y;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_x;
  logic [N-1:0] req1_y;
  logic         req1_sub;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_result;
  logic         rsp_ccn;
  logic         rsp_ccz;
  logic         rsp_ccv;
  logic         rsp_ccc;

  modport master (
    output req0_valid, req0_x, req0_y, req0_sub,
    output req1_valid, req1_x, req1_y, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_ccn, rsp_ccz, rsp_ccv, rsp_ccc
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_sub,
    input  req1_valid, req1_x, req1_y, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_ccn, rsp_ccz, rsp_ccv, rsp_ccc
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared N-bit add/sub datapath.
// The granted operation is computed combinationally and captured in a single response
// slot (EMPTY/FULL) together with N/Z/V/C flags and the owner id.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : addsub_arbiter_if.slave (requests, ready outputs, response slot)
//   sticky_clr : (ADDSUB_ARB_STICKY_V_EN only) clear the sticky overflow flag
//   sticky_v   : (ADDSUB_ARB_STICKY_V_EN only) set by any transfer with ccv=1
//
// Optional feature macro: ADDSUB_ARB_STICKY_V_EN.
module addsub_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  addsub_arbiter_if.slave bus
`ifdef ADDSUB_ARB_STICKY_V_EN
  ,
  input  logic            sticky_clr,
  output logic            sticky_v
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e       state_q, state_d;
  logic         last_q, last_d;      // requester granted at the most recent transfer
  logic         id_q, id_d;
  logic [N-1:0] result_q, result_d;
  logic         ccn_q, ccn_d;
  logic         ccz_q, ccz_d;
  logic         ccv_q, ccv_d;
  logic         ccc_q, ccc_d;

  logic         can_accept;
  logic         grant;
  logic         ready0, ready1;
  logic         xfer;

  logic [N-1:0] op_x, op_y;
  logic         op_sub;
  logic [N:0]   sum;
  logic [N-1:0] res;
  logic         flag_v;

  // Arbitration depends only on valids, rsp_ready, slot state and pointer.
  always_comb begin
    can_accept = (state_q == StEmpty) || bus.rsp_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_q;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
    // rst_n gating keeps both readys low while reset is asserted.
    ready0 = rst_n && can_accept && bus.req0_valid && !grant;
    ready1 = rst_n && can_accept && bus.req1_valid && grant;
    xfer   = ready0 || ready1;
  end

  // Shared datapath; subtraction is x + ~y + 1 so the carry-out means "no borrow".
  always_comb begin
    op_x   = grant ? bus.req1_x   : bus.req0_x;
    op_y   = grant ? bus.req1_y   : bus.req0_y;
    op_sub = grant ? bus.req1_sub : bus.req0_sub;
    sum    = {1'b0, op_x} + {1'b0, (op_sub ? ~op_y : op_y)} + {{N{1'b0}}, op_sub};
    res    = sum[N-1:0];
    if (op_sub) begin
      flag_v = (op_x[N-1] != op_y[N-1]) && (res[N-1] != op_x[N-1]);
    end else begin
      flag_v = (op_x[N-1] == op_y[N-1]) && (res[N-1] != op_x[N-1]);
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    result_d = result_q;
    ccn_d    = ccn_q;
    ccz_d    = ccz_q;
    ccv_d    = ccv_q;
    ccc_d    = ccc_q;
    if (xfer) begin
      state_d  = StFull;
      last_d   = grant;
      id_d     = grant;
      result_d = res;
      ccn_d    = res[N-1];
      ccz_d    = (res == '0);
      ccv_d    = flag_v;
      ccc_d    = sum[N];
    end else if ((state_q == StFull) && bus.rsp_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      last_q   <= 1'b1;              // req0 wins the first contention
      id_q     <= 1'b0;
      result_q <= '0;
      ccn_q    <= 1'b0;
      ccz_q    <= 1'b0;
      ccv_q    <= 1'b0;
      ccc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      result_q <= result_d;
      ccn_q    <= ccn_d;
      ccz_q    <= ccz_d;
      ccv_q    <= ccv_d;
      ccc_q    <= ccc_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state_q == StFull);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_ccn    = ccn_q;
  assign bus.rsp_ccz    = ccz_q;
  assign bus.rsp_ccv    = ccv_q;
  assign bus.rsp_ccc    = ccc_q;

`ifdef ADDSUB_ARB_STICKY_V_EN
  logic sticky_q, sticky_d;

  // Set has priority over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (xfer && flag_v) begin
      sticky_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_v = sticky_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  addsub_arbiter_if #(.N(8)) bus ();

`ifdef ADDSUB_ARB_STICKY_V_EN
  logic sticky_clr;
  logic sticky_v;
`endif

  addsub_arbiter #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef ADDSUB_ARB_STICKY_V_EN
    ,
    .sticky_clr(sticky_clr),
    .sticky_v  (sticky_v)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [7:0] x0, input logic [7:0] y0,
                         input logic s0, input logic v1, input logic [7:0] x1,
                         input logic [7:0] y1, input logic s1);
    bus.req0_valid = v0;
    bus.req0_x     = x0;
    bus.req0_y     = y0;
    bus.req0_sub   = s0;
    bus.req1_valid = v1;
    bus.req1_x     = x1;
    bus.req1_y     = y1;
    bus.req1_sub   = s1;
  endtask

  // Observed response: {id, n, z, v, c, result}
  function automatic logic [12:0] obs();
    return {bus.rsp_id, bus.rsp_ccn, bus.rsp_ccz, bus.rsp_ccv, bus.rsp_ccc, bus.rsp_result};
  endfunction

  // Reference built from integer arithmetic rather than bit tricks.
  function automatic logic [12:0] model(input logic id, input logic [7:0] x,
                                        input logic [7:0] y, input logic s);
    int ux, uy, us, sx, sy, ss;
    logic [7:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    us = s ? (ux - uy) : (ux + uy);
    ss = s ? (sx - sy) : (sx + sy);
    r  = us[7:0];
    c  = s ? (ux >= uy) : (us > 255);
    v  = (ss > 127) || (ss < -128);
    return {id, r[7], (r == 8'h00), v, c, r};
  endfunction

  logic [7:0] vals [10];

  initial begin
    vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F};

    // Reset state: slot empty, outputs zero, readys low even with requests pending.
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h05, 8'h05, 1'b1);
`ifdef ADDSUB_ARB_STICKY_V_EN
    sticky_clr = 1'b0;
`endif
    #2;
    check("reset_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp", 32'(obs()), 32'd0);
    check("reset_ready0", 32'(bus.req0_ready), 32'd0);
    check("reset_ready1", 32'(bus.req1_ready), 32'd0);
`ifdef ADDSUB_ARB_STICKY_V_EN
    check("reset_sticky", 32'(sticky_v), 32'd0);
`endif

    // Overflowing add from req0.
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    check("add_ready0", 32'(bus.req0_ready), 32'd1);
    check("add_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    check("add_valid", 32'(bus.rsp_valid), 32'd1);
    check("add_7f_01", 32'(obs()), 32'(13'b0_1010_10000000));

    // Subtractions from req1.
    set_req(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h05, 1'b1);
    #1;
    check("sub_ready1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    check("sub_05_05", 32'(obs()), 32'(13'b1_0101_00000000));
    set_req(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 8'h01, 1'b1);
    @(posedge clk); #1;
    check("sub_80_01", 32'(obs()), 32'(13'b1_0011_01111111));

    // Drain with no new request.
    set_req(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("drain_valid", 32'(bus.rsp_valid), 32'd0);

    // Contention: last grant was req1, so grants go 0,1,0,1.
    set_req(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h10, 8'h03, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = (i % 2 == 1);
      #1;
      check("rr_ready0", 32'(bus.req0_ready), 32'(!e));
      check("rr_ready1", 32'(bus.req1_ready), 32'(e));
      @(posedge clk); #1;
      check("rr_rsp", 32'(obs()), 32'(e ? 13'b1_0001_00001101 : 13'b0_0000_00110011));
    end

    // Back-pressure: slot holds req1's 0x0D, both requests stall.
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 8'h20, 8'h03, 1'b0, 1'b1, 8'h10, 8'h03, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready0", 32'(bus.req0_ready), 32'd0);
      check("hold_ready1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp", 32'(obs()), 32'(13'b1_0001_00001101));
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("release_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    check("release_valid", 32'(bus.rsp_valid), 32'd1);
    check("release_rsp", 32'(obs()), 32'(13'b0_0000_00100011));

    // Mid-cycle reset while FULL; pointer was 0, must return to 1.
    bus.rsp_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rsp", 32'(obs()), 32'd0);
    check("midrst_ready0", 32'(bus.req0_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_noxfer", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready0", 32'(bus.req0_ready), 32'd1);
    check("postrst_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    check("postrst_rsp", 32'(obs()), 32'(13'b0_0000_00100011));

    // Corner-value sweep through each port, both ops, back to back.
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 10; i++) begin
          for (int j = 0; j < 10; j++) begin
            if (p == 0) set_req(1'b1, vals[i], vals[j], s[0], 1'b0, 8'h00, 8'h00, 1'b0);
            else        set_req(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, vals[i], vals[j], s[0]);
            @(posedge clk); #1;
            check("sweep", 32'(obs()), 32'(model(p[0], vals[i], vals[j], s[0])));
          end
        end
      end
    end

`ifdef ADDSUB_ARB_STICKY_V_EN
    set_req(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    check("sticky_clr0", 32'(sticky_v), 32'd0);
    sticky_clr = 1'b0;
    set_req(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("sticky_set", 32'(sticky_v), 32'd1);
    sticky_clr = 1'b1;
    set_req(1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("sticky_setwins", 32'(sticky_v), 32'd1);
    set_req(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("sticky_clr1", 32'(sticky_v), 32'd0);
    sticky_clr = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
